// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared state type, keymap and vector helpers for keypad_scanner.
// Revision : 1.0
// ============================================================================
package keypad_pkg;
    localparam int c_num_rows = 4;
    localparam int c_num_cols = 4;
    localparam int c_num_keys = c_num_rows * c_num_cols;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKOUT = 2'd2
    } kp_state_t;

    // Indexed by row*4 + col; the bottom row reads 0,F,E,D on the PmodKYPD.
    localparam logic [3:0] c_keymap [c_num_keys] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [4:0] count_keys(input logic [c_num_keys-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < c_num_keys; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [3:0] lowest_key(input logic [c_num_keys-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = c_num_keys - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction
endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce
// Brief    : Accepts a scan vector once it repeats for DEBOUNCE_SCANS scans.
// Revision : 1.0
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [c_num_keys-1:0] scan_vec,
    input  logic                  scan_done,
    output logic [c_num_keys-1:0] stable_vec,
    output logic                  stable_upd
);
    localparam int c_cnt_w = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(DEBOUNCE_SCANS - 1);

    logic [c_num_keys-1:0] r_last_scan;
    logic [c_num_keys-1:0] r_stable_vec;
    logic                  r_stable_upd;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_next;

    // Counter saturates at the acceptance point, so a steady pattern is re-offered every scan.
    always_comb begin
        w_cnt_next = '0;
        if (scan_vec == r_last_scan) begin
            w_cnt_next = (r_cnt == c_cnt_top) ? r_cnt : r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_last_scan  <= '0;
            r_stable_vec <= '0;
            r_stable_upd <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_stable_upd <= 1'b0;
            if (scan_done) begin
                r_last_scan <= scan_vec;
                r_cnt       <= w_cnt_next;
                if (w_cnt_next == c_cnt_top) begin
                    r_stable_vec <= scan_vec;
                    r_stable_upd <= 1'b1;
                end
            end
        end
    end

    assign stable_vec = r_stable_vec;
    assign stable_upd = r_stable_upd;
endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 keypad column scan, debounce and single-key accept FSM.
//            Define KEYPAD_HISTORY_EN to build the 4-digit key history.
// Revision : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0
);
    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

    logic [3:0]            r_row_meta;
    logic [3:0]            r_row_sync;
    logic [c_div_w-1:0]    r_div;
    logic [1:0]            r_col_idx;
    logic [3:0]            r_col;
    logic [c_num_keys-1:0] r_scan_acc;
    logic [c_num_keys-1:0] w_scan_vec;
    logic                  w_sample;
    logic                  w_scan_done;
    logic [c_num_keys-1:0] w_stable_vec;
    logic                  w_stable_upd;
    logic [4:0]            w_nkeys;
    logic [3:0]            w_code;
    kp_state_t             r_state;
    logic [3:0]            r_key;
    logic                  r_key_valid;
    logic                  r_key_held;

    assign w_sample    = (r_div == c_div_last);
    assign w_scan_done = w_sample && (r_col_idx == 2'd3);

    for (genvar gr = 0; gr < c_num_rows; gr++) begin : g_row
        for (genvar gc = 0; gc < c_num_cols; gc++) begin : g_col
            assign w_scan_vec[gr*c_num_cols+gc] = (r_col_idx == 2'(gc)) ? ~r_row_sync[gr]
                                                                        : r_scan_acc[gr*c_num_cols+gc];
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
            r_div      <= '0;
            r_col_idx  <= 2'd0;
            r_col      <= 4'b1110;
            r_scan_acc <= '0;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_div      <= '0;
                r_col_idx  <= r_col_idx + 2'd1;
                r_col      <= {r_col[2:0], r_col[3]};
                r_scan_acc <= w_scan_vec;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .clear_n    (clear_n),
        .scan_vec   (w_scan_vec),
        .scan_done  (w_scan_done),
        .stable_vec (w_stable_vec),
        .stable_upd (w_stable_upd)
    );

    assign w_nkeys = count_keys(w_stable_vec);
    assign w_code  = c_keymap[lowest_key(w_stable_vec)];

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state     <= IDLE;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_stable_upd) begin
                case (r_state)
                    IDLE: begin
                        if (w_nkeys == 5'd1) begin
                            r_state     <= PRESSED;
                            r_key       <= w_code;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                        end else if (w_nkeys != 5'd0) begin
                            r_state <= LOCKOUT;
                        end
                    end
                    PRESSED: begin
                        if (w_nkeys == 5'd0) begin
                            r_state    <= IDLE;
                            r_key_held <= 1'b0;
                        end else if (w_nkeys != 5'd1 || w_code != r_key) begin
                            r_state    <= LOCKOUT;
                            r_key_held <= 1'b0;
                        end
                    end
                    LOCKOUT: begin
                        if (w_nkeys == 5'd0) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_key_held <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_HISTORY_EN
    logic       w_accept;
    logic [3:0] r_digit [4];

    assign w_accept = w_stable_upd && (r_state == IDLE) && (w_nkeys == 5'd1);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_digit <= '{default: 4'h0};
        end else if (w_accept) begin
            r_digit[3] <= r_digit[2];
            r_digit[2] <= r_digit[1];
            r_digit[1] <= r_digit[0];
            r_digit[0] <= w_code;
        end
    end

    assign digit3 = r_digit[3];
    assign digit2 = r_digit[2];
    assign digit1 = r_digit[1];
    assign digit0 = r_digit[0];
`else
    assign digit3 = 4'h0;
    assign digit2 = 4'h0;
    assign digit1 = 4'h0;
    assign digit0 = 4'h0;
`endif

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
endmodule
`default_nettype wire
